// File: rtl/row_fetch_arbiter_pkg.sv
// Shared definitions for the row fetch arbiter: geometry, pixel packing
// offsets and the fetch FSM state encoding.
package row_fetch_arbiter_pkg;

  localparam int COLOR_BITS    = 4;
  localparam int COL_ADDR_BITS = 6;
  localparam int ROW_ADDR_BITS = 4;
  localparam int COLOR_COUNT   = 3;
  localparam int FETCH_BURST   = 8;

  localparam int NUM_COL       = 2**COL_ADDR_BITS;
  localparam int PIX_BITS      = COLOR_BITS*COLOR_COUNT;
  localparam int ROW_DAT_WIDTH = NUM_COL*PIX_BITS;
  localparam int RAM_ADDR_BITS = ROW_ADDR_BITS+COL_ADDR_BITS;
  localparam int BURST_W       = $clog2(FETCH_BURST+1);

  // Channel offsets inside one pixel word (R low, then G, then B).
  localparam int R_OFS = 0;
  localparam int G_OFS = COLOR_BITS;
  localparam int B_OFS = 2*COLOR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/row_fetch_arbiter_if.sv
// Writer handshake plus single-port frame RAM bus.
//   wr_valid/wr_ready/wr_row/wr_col/wr_data : pixel writer request
//   ram_addr/ram_we/ram_wdata/ram_rdata      : RAM port ({row,col} address,
//                                              read data one cycle late)
// slave  = arbiter side, master = writer/RAM side.
interface row_fetch_arbiter_if;
  import row_fetch_arbiter_pkg::*;

  logic                     wr_valid;
  logic                     wr_ready;
  logic [ROW_ADDR_BITS-1:0] wr_row;
  logic [COL_ADDR_BITS-1:0] wr_col;
  logic [PIX_BITS-1:0]      wr_data;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     ram_we;
  logic [PIX_BITS-1:0]      ram_wdata;
  logic [PIX_BITS-1:0]      ram_rdata;

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output wr_valid, wr_row, wr_col, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/row_fetch_arbiter_row_assembler.sv
// Row staging buffer with indexed pixel capture and atomic commit.
//   capture_en/cap_col/cap_data : write one pixel into staging
//   commit/commit_idx           : copy staging (including a same-cycle
//                                 capture) to row_out and tag it
//   row_out/row_out_idx/row_valid : committed row
module row_assembler
  import row_fetch_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture_en,
  input  logic [COL_ADDR_BITS-1:0] cap_col,
  input  logic [PIX_BITS-1:0]      cap_data,
  input  logic                     commit,
  input  logic [ROW_ADDR_BITS-1:0] commit_idx,
  output logic [ROW_DAT_WIDTH-1:0] row_out,
  output logic [ROW_ADDR_BITS-1:0] row_out_idx,
  output logic                     row_valid
);

  logic [ROW_DAT_WIDTH-1:0] staging_q, staging_d;
  logic [ROW_DAT_WIDTH-1:0] row_out_q, row_out_d;
  logic [ROW_ADDR_BITS-1:0] row_out_idx_q, row_out_idx_d;
  logic                     row_valid_q, row_valid_d;

  always_comb begin
    staging_d     = staging_q;
    row_out_d     = row_out_q;
    row_out_idx_d = row_out_idx_q;
    row_valid_d   = row_valid_q;
    if (capture_en) staging_d[int'(cap_col)*PIX_BITS +: PIX_BITS] = cap_data;
    // Commit sees the pixel captured on the same edge (last column of a row).
    if (commit) begin
      row_out_d     = staging_d;
      row_out_idx_d = commit_idx;
      row_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q     <= '0;
      row_out_q     <= '0;
      row_out_idx_q <= '0;
      row_valid_q   <= 1'b0;
    end else begin
      staging_q     <= staging_d;
      row_out_q     <= row_out_d;
      row_out_idx_q <= row_out_idx_d;
      row_valid_q   <= row_valid_d;
    end
  end

  assign row_out     = row_out_q;
  assign row_out_idx = row_out_idx_q;
  assign row_valid   = row_valid_q;

endmodule

// File: rtl/row_fetch_arbiter.sv
// Arbitrates one single-port frame RAM between the display row prefetch and
// a pixel writer. Fetches display_row one pixel per cycle into a staging
// buffer and commits the whole row atomically.
//   clk, rst_n      : clock, async active-low reset
//   display_row     : row requested by the display
//   row_out*        : committed row, its index and valid flag
//   fetch_overrun   : sticky, display_row changed while a fetch was running
//   bus (slave)     : writer handshake and RAM port
//
// state | meaning
// IDLE  | no fetch running; writer granted whenever it asks
// FETCH | one read per cycle, except a yield slot after FETCH_BURST reads
// DRAIN | capture last read and commit (or yield first if a write waits)
module row_fetch_arbiter
  import row_fetch_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROW_ADDR_BITS-1:0] display_row,
  output logic [ROW_DAT_WIDTH-1:0] row_out,
  output logic [ROW_ADDR_BITS-1:0] row_out_idx,
  output logic                     row_valid,
  output logic                     fetch_overrun,
  row_fetch_arbiter_if.slave       bus
);

  localparam logic [BURST_W-1:0]       BURST_MAX = BURST_W'(FETCH_BURST);
  localparam logic [COL_ADDR_BITS-1:0] LAST_COL  = COL_ADDR_BITS'(NUM_COL-1);

  state_t                   state_q, state_d;
  logic [COL_ADDR_BITS-1:0] col_q, col_d;
  logic [ROW_ADDR_BITS-1:0] target_q, target_d;
  logic [BURST_W-1:0]       burst_q, burst_d;
  logic [ROW_ADDR_BITS-1:0] last_row_q, last_row_d;
  logic                     last_valid_q, last_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     cap_en_q, cap_en_d;
  logic [COL_ADDR_BITS-1:0] cap_col_q, cap_col_d;

  logic                     fetch_req, yield, commit, wr_grant;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     ram_we;
  logic [PIX_BITS-1:0]      ram_wdata;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    target_d     = target_q;
    burst_d      = burst_q;
    overrun_d    = overrun_q;
    last_row_d   = display_row;
    last_valid_d = 1'b1;
    cap_en_d     = 1'b0;
    cap_col_d    = col_q;
    commit       = 1'b0;
    wr_grant     = 1'b0;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = '0;

    // Any one-cycle difference counts, including a return to the old row.
    fetch_req = !last_valid_q || (display_row != last_row_q);
    yield     = (burst_q == BURST_MAX) && bus.wr_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d  = ST_FETCH;
          col_d    = '0;
          target_d = display_row;
          burst_d  = '0;
        end else begin
          wr_grant = bus.wr_valid;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        if (fetch_req) begin
          // Abort: staging contents are simply overwritten by the restart.
          state_d   = ST_FETCH;
          col_d     = '0;
          target_d  = display_row;
          burst_d   = '0;
          overrun_d = 1'b1;
        end else if (yield) begin
          wr_grant = 1'b1;
          burst_d  = '0;
        end else if (state_q == ST_FETCH) begin
          ram_addr  = {target_q, col_q};
          cap_en_d  = 1'b1;
          cap_col_d = col_q;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
          if (col_q == LAST_COL) begin
            state_d = ST_DRAIN;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_grant) begin
      ram_we    = 1'b1;
      ram_addr  = {bus.wr_row, bus.wr_col};
      ram_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      target_q     <= '0;
      burst_q      <= '0;
      last_row_q   <= '0;
      last_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      cap_en_q     <= 1'b0;
      cap_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      target_q     <= target_d;
      burst_q      <= burst_d;
      last_row_q   <= last_row_d;
      last_valid_q <= last_valid_d;
      overrun_q    <= overrun_d;
      cap_en_q     <= cap_en_d;
      cap_col_q    <= cap_col_d;
    end
  end

  row_assembler u_row_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_en (cap_en_q),
    .cap_col    (cap_col_q),
    .cap_data   (bus.ram_rdata),
    .commit     (commit),
    .commit_idx (target_q),
    .row_out    (row_out),
    .row_out_idx(row_out_idx),
    .row_valid  (row_valid)
  );

  assign bus.wr_ready  = wr_grant;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_we    = ram_we;
  assign bus.ram_wdata = ram_wdata;
  assign fetch_overrun = overrun_q;

endmodule

// File: tb/tb_row_fetch_arbiter.sv
module tb_row_fetch_arbiter;
  import row_fetch_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [ROW_ADDR_BITS-1:0] display_row;
  logic [ROW_DAT_WIDTH-1:0] row_out;
  logic [ROW_ADDR_BITS-1:0] row_out_idx;
  logic row_valid, fetch_overrun;

  row_fetch_arbiter_if bus();

  row_fetch_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .display_row  (display_row),
    .row_out      (row_out),
    .row_out_idx  (row_out_idx),
    .row_valid    (row_valid),
    .fetch_overrun(fetch_overrun),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Reference image of RAM contents and the RAM itself.
  logic [PIX_BITS-1:0] img [0:(2**RAM_ADDR_BITS)-1];
  logic [PIX_BITS-1:0] mem [0:(2**RAM_ADDR_BITS)-1];
  logic [PIX_BITS-1:0] rdata_q;
  logic copy_req = 1'b0;

  always @(posedge clk) begin
    if (copy_req) begin
      for (int a = 0; a < 2**RAM_ADDR_BITS; a++) mem[a] <= img[a];
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    rdata_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rdata_q;

  int checks = 0;
  int errors = 0;
  localparam int IDLE_LAT = NUM_COL + 2;

  function automatic logic [ROW_DAT_WIDTH-1:0] exp_row(input logic [ROW_ADDR_BITS-1:0] r);
    logic [ROW_DAT_WIDTH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_COL; c++) v[c*PIX_BITS +: PIX_BITS] = img[{r, COL_ADDR_BITS'(c)}];
    return v;
  endfunction

  task automatic copy_image();
    copy_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    copy_req = 1'b0;
  endtask

  task automatic wait_commit(input logic [ROW_ADDR_BITS-1:0] r, input int start, output int cyc);
    int k;
    k = start;
    cyc = -1;
    while (k < start + 400) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (row_valid === 1'b1 && row_out_idx === r) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    display_row = 4'd3;
    bus.wr_valid = 1'b1;
    bus.wr_row = 4'd1;
    bus.wr_col = 6'd1;
    bus.wr_data = 12'h555;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (row_out !== '0 || row_out_idx !== '0 || row_valid !== 1'b0 || fetch_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: idx=%0d valid=%b overrun=%b row_nonzero=%b, required all 0",
               row_out_idx, row_valid, fetch_overrun, |row_out);
    end
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_ram: wr_ready=%b ram_we=%b addr=%h wdata=%h, required 0",
               bus.wr_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.wr_valid = 1'b0;
    for (int a = 0; a < 2**RAM_ADDR_BITS; a++) img[a] = PIX_BITS'(a);
    copy_image();
  endtask

  task automatic test_first_fetch();
    int cyc;
    logic [PIX_BITS-1:0] p5;
    rst_n = 1'b1;
    wait_commit(4'd3, 0, cyc);
    checks++;
    if (cyc !== IDLE_LAT) begin
      errors++;
      $display("FAIL first_fetch_latency: got %0d required %0d", cyc, IDLE_LAT);
    end
    checks++;
    if (row_out !== exp_row(4'd3)) begin
      errors++;
      $display("FAIL first_fetch_row: got %h required %h", row_out, exp_row(4'd3));
    end
    p5 = row_out[5*PIX_BITS +: PIX_BITS];
    checks++;
    if (p5 !== 12'h0C5) begin
      errors++;
      $display("FAIL first_fetch_pixel5: got %h required %h", p5, 12'h0C5);
    end
  endtask

  task automatic test_idle_write();
    int cyc;
    logic v;
    logic [PIX_BITS-1:0] p10;
    bus.wr_valid = 1'b1;
    bus.wr_row = 4'd5;
    bus.wr_col = 6'd10;
    bus.wr_data = 12'hABC;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== {4'd5, 6'd10} || bus.ram_wdata !== 12'hABC) begin
      errors++;
      $display("FAIL idle_write_grant: ready=%b we=%b addr=%h wdata=%h, required 1 1 %h abc",
               bus.wr_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata, {4'd5, 6'd10});
    end
    img[{4'd5, 6'd10}] = 12'hABC;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    display_row = 4'd5;
    wait_commit(4'd5, 0, cyc);
    p10 = row_out[10*PIX_BITS +: PIX_BITS];
    checks++;
    if (cyc !== IDLE_LAT || p10 !== 12'hABC) begin
      errors++;
      $display("FAIL idle_write_readback: cycle %0d pixel10 %h, required %0d abc", cyc, p10, IDLE_LAT);
    end
    // Random idle traffic: a grant must follow wr_valid exactly.
    for (int i = 0; i < 20; i++) begin
      v = 1'($urandom_range(0, 1));
      bus.wr_valid = v;
      bus.wr_row = 4'($urandom);
      bus.wr_col = 6'($urandom);
      bus.wr_data = 12'($urandom);
      #1;
      checks++;
      if (bus.wr_ready !== v || bus.ram_we !== v ||
          (v && (bus.ram_addr !== {bus.wr_row, bus.wr_col} || bus.ram_wdata !== bus.wr_data))) begin
        errors++;
        $display("FAIL idle_random_write: ready=%b we=%b addr=%h, required %b %b %h",
                 bus.wr_ready, bus.ram_we, bus.ram_addr, v, v, {bus.wr_row, bus.wr_col});
      end
      if (v) img[{bus.wr_row, bus.wr_col}] = bus.wr_data;
      @(posedge clk);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_burst_writes();
    int k, cyc, grants;
    logic [ROW_ADDR_BITS-1:0] r;
    logic g;
    do r = 4'($urandom); while (r == 4'd4 || r == 4'd5);
    display_row = r;
    bus.wr_valid = 1'b1;
    do bus.wr_row = 4'($urandom); while (bus.wr_row == r);
    bus.wr_col = 6'($urandom);
    bus.wr_data = 12'($urandom);
    k = 0;
    cyc = -1;
    grants = 0;
    while (k < 400) begin
      #1;
      g = bus.wr_ready;
      if (g === 1'b1) begin
        grants++;
        img[{bus.wr_row, bus.wr_col}] = bus.wr_data;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (row_valid === 1'b1 && row_out_idx === r) begin
        cyc = k;
        break;
      end
      if (g === 1'b1) begin
        do bus.wr_row = 4'($urandom); while (bus.wr_row == r);
        bus.wr_col = 6'($urandom);
        bus.wr_data = 12'($urandom);
      end
    end
    bus.wr_valid = 1'b0;
    checks++;
    if (grants !== NUM_COL / FETCH_BURST) begin
      errors++;
      $display("FAIL burst_grant_count: got %0d required %0d", grants, NUM_COL / FETCH_BURST);
    end
    checks++;
    if (cyc !== IDLE_LAT + NUM_COL / FETCH_BURST) begin
      errors++;
      $display("FAIL burst_commit_latency: got %0d required %0d", cyc, IDLE_LAT + NUM_COL / FETCH_BURST);
    end
    checks++;
    if (row_out !== exp_row(r)) begin
      errors++;
      $display("FAIL burst_row_data: got %h required %h", row_out, exp_row(r));
    end
  endtask

  task automatic test_overrun();
    int k, cyc, stale;
    logic [ROW_DAT_WIDTH-1:0] exp4;
    display_row = 4'd4;
    wait_commit(4'd4, 0, cyc);
    checks++;
    if (fetch_overrun !== 1'b0 || cyc !== IDLE_LAT) begin
      errors++;
      $display("FAIL overrun_pre: overrun=%b cycle=%0d, required 0 %0d", fetch_overrun, cyc, IDLE_LAT);
    end
    exp4 = exp_row(4'd4);
    display_row = 4'd12;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    display_row = 4'd5;
    k = 0;
    cyc = -1;
    stale = 0;
    while (k < 400) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (row_valid === 1'b1 && row_out_idx === 4'd5) begin
        cyc = k;
        break;
      end
      if (row_out !== exp4 || row_out_idx !== 4'd4) stale++;
    end
    checks++;
    if (fetch_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b required 1", fetch_overrun);
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL overrun_hold_old_row: %0d cycles disturbed, required 0", stale);
    end
    checks++;
    if (cyc !== IDLE_LAT || row_out !== exp_row(4'd5)) begin
      errors++;
      $display("FAIL overrun_new_commit: cycle %0d required %0d, row %h required %h",
               cyc, IDLE_LAT, row_out, exp_row(4'd5));
    end
    // Brief excursion to another row and back must restart the fetch.
    display_row = 4'd9;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    display_row = 4'd10;
    @(posedge clk);
    @(negedge clk);
    display_row = 4'd9;
    wait_commit(4'd9, 0, cyc);
    checks++;
    if (cyc !== IDLE_LAT || row_out !== exp_row(4'd9)) begin
      errors++;
      $display("FAIL bounce_restart: cycle %0d required %0d, row %h required %h",
               cyc, IDLE_LAT, row_out, exp_row(4'd9));
    end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc;
    display_row = 4'd11;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (row_out !== '0 || row_out_idx !== '0 || row_valid !== 1'b0 || fetch_overrun !== 1'b0 ||
        bus.wr_ready !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
      errors++;
      $display("FAIL midfetch_reset: idx=%0d valid=%b overrun=%b we=%b addr=%h row_nonzero=%b, required all 0",
               row_out_idx, row_valid, fetch_overrun, bus.ram_we, bus.ram_addr, |row_out);
    end
    for (int a = 0; a < 2**RAM_ADDR_BITS; a++) img[a] = 12'($urandom);
    @(negedge clk);
    copy_image();
    rst_n = 1'b1;
    wait_commit(4'd11, 0, cyc);
    checks++;
    if (cyc !== IDLE_LAT || row_out !== exp_row(4'd11)) begin
      errors++;
      $display("FAIL midfetch_reset_refetch: cycle %0d required %0d, row %h required %h",
               cyc, IDLE_LAT, row_out, exp_row(4'd11));
    end
  endtask

  task automatic test_write_fetched_row();
    int k, cyc, grants;
    logic [ROW_DAT_WIDTH-1:0] snap;
    logic [PIX_BITS-1:0] old_p, new_p, p2;
    logic g;
    snap = exp_row(4'd7);
    old_p = img[{4'd7, 6'd2}];
    new_p = old_p ^ 12'h5A5;
    display_row = 4'd7;
    k = 0;
    repeat (5) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    bus.wr_valid = 1'b1;
    bus.wr_row = 4'd7;
    bus.wr_col = 6'd2;
    bus.wr_data = new_p;
    cyc = -1;
    grants = 0;
    while (k < 400) begin
      #1;
      g = bus.wr_valid & bus.wr_ready;
      if (g === 1'b1) grants++;
      @(posedge clk);
      k++;
      @(negedge clk);
      if (g === 1'b1) bus.wr_valid = 1'b0;
      if (row_valid === 1'b1 && row_out_idx === 4'd7) begin
        cyc = k;
        break;
      end
    end
    bus.wr_valid = 1'b0;
    p2 = row_out[2*PIX_BITS +: PIX_BITS];
    checks++;
    if (grants !== 1 || cyc !== IDLE_LAT + 1) begin
      errors++;
      $display("FAIL midfetch_write_slot: grants %0d cycle %0d, required 1 %0d", grants, cyc, IDLE_LAT + 1);
    end
    checks++;
    if (p2 !== old_p || row_out !== snap) begin
      errors++;
      $display("FAIL no_forwarding: pixel2 %h required %h", p2, old_p);
    end
    img[{4'd7, 6'd2}] = new_p;
    display_row = 4'd3;
    wait_commit(4'd3, 0, cyc);
    display_row = 4'd7;
    wait_commit(4'd7, 0, cyc);
    p2 = row_out[2*PIX_BITS +: PIX_BITS];
    checks++;
    if (cyc !== IDLE_LAT || p2 !== new_p || row_out !== exp_row(4'd7)) begin
      errors++;
      $display("FAIL refetch_new_value: cycle %0d pixel2 %h, required %0d %h", cyc, p2, IDLE_LAT, new_p);
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_row = '0;
    bus.wr_col = '0;
    bus.wr_data = '0;
    test_reset();
    test_first_fetch();
    test_idle_write();
    test_burst_writes();
    test_overrun();
    test_reset_mid_fetch();
    test_write_fetched_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_fetch_arbiter.md
Name: row_fetch_arbiter

Overview:
- Shares one single-port frame RAM between two users:
  - the display row prefetch, which feeds display_control's row_in;
  - a pixel writer (host/pattern generator) using a valid/ready handshake.
- Watches display_control's next_row and fetches that row, one pixel per read, into a staging buffer.
- Commits the whole row atomically to row_out.
- Writes are granted whenever the RAM is idle, plus one guaranteed slot after every FETCH_BURST consecutive reads.

Parameters:
- COLOR_BITS, 4: bits per colour channel.
- COL_ADDR_BITS, 6: column address bits; NUM_COL = 2**COL_ADDR_BITS.
- ROW_ADDR_BITS, 4: row address bits.
- COLOR_COUNT, 3: channels per pixel; PIX_BITS = COLOR_BITS*COLOR_COUNT.
- FETCH_BURST, 8: maximum back-to-back reads before a waiting write must be granted (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- display_row  in  ROW_ADDR_BITS  row requested by display_control (its next_row).
- row_out  out  NUM_COL*PIX_BITS  committed row to display_control row_in.
- row_out_idx  out  ROW_ADDR_BITS  row index held in row_out.
- row_valid  out  1  row_out holds a completed fetch.
- fetch_overrun  out  1  sticky: display_row changed while a fetch was in progress.
- wr_valid  in  1  writer request.
- wr_ready  out  1  write granted this cycle.
- wr_row  in  ROW_ADDR_BITS  write row.
- wr_col  in  COL_ADDR_BITS  write column.
- wr_data  in  PIX_BITS  pixel data.
- ram_addr  out  ROW_ADDR_BITS+COL_ADDR_BITS  {row,col}.
- ram_we  out  1  write strobe.
- ram_wdata  out  PIX_BITS  write data.
- ram_rdata  in  PIX_BITS  read data, valid exactly 1 cycle after the address.

Behaviour:

Reset (asynchronous, while rst_n=0):
- row_out=0, row_out_idx=0, row_valid=0, fetch_overrun=0, wr_ready=0, ram_we=0, ram_addr=0, ram_wdata=0.
- State=IDLE; last_row is marked invalid.

Pixel packing:
- Pixel c occupies row_out[c*PIX_BITS +: PIX_BITS].
- Within a pixel: R in the low COLOR_BITS, then G, then B.
- The RAM word uses the same packing.

Row-change detection:
- last_row is registered from display_row.
- A fetch is requested when display_row != last_row, or when last_row is invalid (first cycle after reset release).

States:
- IDLE:
  - Fetch request -> FETCH with col=0 and target=display_row.
  - Otherwise, wr_ready=wr_valid, and a granted write is performed that cycle.
- FETCH:
  - Each cycle: ram_addr={target,col}, ram_we=0, col++.
  - burst_cnt counts consecutive reads.
  - If burst_cnt==FETCH_BURST and wr_valid=1: yield one cycle to the write, no read, burst_cnt=0.
  - If wr_valid=0, no yield is taken and burst_cnt saturates.
  - After the read of col=NUM_COL-1 -> DRAIN.
- DRAIN (1 cycle):
  - Capture the last ram_rdata.
  - row_out <= staging, row_out_idx <= target, row_valid <= 1.
  - -> IDLE.

Read capture:
- The read issued at cycle t is written into staging[col] at the edge ending cycle t+1.
- A yield cycle captures the preceding read; the write does not disturb capture.

Write grant:
- wr_ready is combinational from state, burst_cnt and wr_valid; it is never asserted without wr_valid.
- On a grant: ram_we=1, ram_addr={wr_row,wr_col}, ram_wdata=wr_data, in the same cycle.
- Transfer occurs when wr_valid & wr_ready.

Latency:
- Fetch request detected in cycle 0 (display_row differs at the edge).
- Reads are issued in cycles 1..NUM_COL, plus one cycle per yield.
- row_out is updated at the end of cycle NUM_COL+1+yields.

Boundary conditions:
- display_row changes during FETCH/DRAIN:
  - Abort: discard staging, restart FETCH at col=0 with the new target.
  - Set fetch_overrun; it is cleared only by reset.
  - row_out is unchanged until a complete fetch commits.
- Write to the row being fetched: no forwarding. Columns already read keep the old data until the next fetch of that row.
- display_row returns to last_row value mid-fetch: this counts as a change; abort and restart.
- col wraps from NUM_COL-1 to 0 only via the state exit; the counter never overflows into the row bits.

Decomposition:
- Shared package: NUM_COL, PIX_BITS, ROW_DAT_WIDTH, the state encoding (IDLE/FETCH/DRAIN), and the pixel-field offset constants.
- Sub-module row_assembler: staging register with indexed capture (col, data, capture_en) and atomic commit to row_out. This is reusable by any future row source.

Test Plan:
- Reset release with display_row=3, RAM preloaded pixel(r,c)={r,c} -> row_out_idx=3 and row_valid=1 at cycle 66 (NUM_COL=64); pixel c of row_out = {3,c}.
- Idle writer: wr_valid=1 with row 5, col 10, data 0xABC and no fetch pending -> wr_ready=1 same cycle, ram_we=1, ram_addr={5,10}; the next fetch of row 5 shows 0xABC at pixel 10.
- wr_valid held during a fetch -> exactly one write granted after each 8 reads (8 grants over 64 reads); commit occurs 8 cycles later than the idle case.
- display_row changes 4->5 at read 20 -> fetch_overrun=1; row_out keeps row 4 data until the complete row 5 commits.
- rst_n asserted mid-fetch at read 30 -> all outputs 0 immediately; after release, a full fetch of the current display_row commits.
- Write to {7,2} while row 7 fetch is past col 2 -> committed row_out pixel 2 has the old value; the next row 7 fetch shows the new value.
